// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter
// Shares the single AHB-lite slave port of the AHB-to-APB bridge between
// NUM_M AHB-lite masters on the Hclk domain.
//
// - Registered round-robin arbitration. The current owner has the lowest
//   priority at the next arbitration point.
// - A burst is never split while the granted master drives SEQ.
// - A MAX_BEATS fairness counter forces the owner to yield at the next
//   non-SEQ point when another master is requesting.
// - The data-phase owner (hmaster_data) is tracked so that Hwdata stays with
//   the master whose address phase was accepted, including across handovers.
//
// Build option: define AHB_ARB_FIXED_PRIO_EN to select fixed priority instead
// (master 0 highest). In that build there is no beat-limit yielding and no
// beat counter.
module ahb_bridge_arbiter #(
    parameter int NUM_M     = 2,   // number of masters, 2..4
    parameter int MAX_BEATS = 8,   // accepted transfers before a forced yield, 1..255
    parameter int DEFAULT_M = 0    // park master when nobody requests
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    input  logic [NUM_M-1:0]    m_hreq,
    input  logic [2*NUM_M-1:0]  m_htrans,
    input  logic [32*NUM_M-1:0] m_haddr,
    input  logic [NUM_M-1:0]    m_hwrite,
    input  logic [32*NUM_M-1:0] m_hwdata,
    output logic [NUM_M-1:0]    m_hgrant,
    input  logic                Hreadyout,
    output logic [1:0]          Htrans,
    output logic [31:0]         Haddr,
    output logic                Hwrite,
    output logic [31:0]         Hwdata,
    output logic                Hreadyin,
    output logic [1:0]          hmaster,
    output logic [1:0]          hmaster_data
);

    // Htrans encodings used by the arbitration rules
    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    // Arbiter states
    localparam logic [0:0] ST_PARK = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [1:0]       DEF_IDX   = 2'(DEFAULT_M);
    localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEFAULT_M;

    // ------------------------------------------------------------------
    // Per-master views, padded to four entries so that a 2-bit master
    // index always selects a real array element.
    // ------------------------------------------------------------------
    logic [3:0]  req4;
    logic [3:0]  write4;
    logic [1:0]  trans4 [4];
    logic [31:0] addr4  [4];
    logic [31:0] wdata4 [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            if (gi < NUM_M) begin : g_used
                assign req4[gi]   = m_hreq[gi];
                assign write4[gi] = m_hwrite[gi];
                assign trans4[gi] = m_htrans[2*gi +: 2];
                assign addr4[gi]  = m_haddr[32*gi +: 32];
                assign wdata4[gi] = m_hwdata[32*gi +: 32];
            end else begin : g_unused
                assign req4[gi]   = 1'b0;
                assign write4[gi] = 1'b0;
                assign trans4[gi] = TR_IDLE;
                assign addr4[gi]  = 32'h0;
                assign wdata4[gi] = 32'h0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [1:0]       hmaster_q, hmaster_d;
    logic [1:0]       hmaster_data_q, hmaster_data_d;
    logic [NUM_M-1:0] grant_q, grant_d;

    // Decoded view of the granted master this cycle
    logic [1:0] g_trans;
    logic       g_req;
    logic       any_req;
    logic       accepted;
    logic       beat_limit;
    logic       own_point;
    logic       arb_point;
    logic [1:0] winner;
    logic       found;

    assign g_trans  = trans4[hmaster_q];
    assign g_req    = req4[hmaster_q];
    assign any_req  = |req4;
    // A transfer is accepted when the bridge is ready and the granted
    // master presents NONSEQ or SEQ (Htrans[1] set).
    assign accepted = Hreadyout & g_trans[1];

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Fixed priority: no fairness yielding, so no beat counter at all.
    assign beat_limit = 1'b0;

    // Lowest-numbered requester wins.
    always_comb begin
        winner = DEF_IDX;
        found  = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && req4[k]) begin
                winner = 2'(k);
                found  = 1'b1;
            end
        end
    end
`else
    localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       other_req;

    // Another master besides the current owner wants the bus
    assign other_req  = |(req4 & ~(4'b0001 << hmaster_q));
    assign beat_limit = (beat_cnt_q == MAX_B) && other_req;

    // Round-robin: search starts just after the current owner, the owner
    // itself is considered last.
    always_comb begin
        int c;
        winner = DEF_IDX;
        found  = 1'b0;
        c      = 0;
        for (int k = 1; k <= NUM_M; k++) begin
            c = int'(hmaster_q) + k;
            if (c >= NUM_M) begin
                c = c - NUM_M;
            end
            if (!found && req4[c[1:0]]) begin
                winner = c[1:0];
                found  = 1'b1;
            end
        end
    end

    // Beat counter: cleared by any arbitration decision (including a
    // regrant to the same master), otherwise counts accepted transfers and
    // saturates at the limit. A stall (Hreadyout=0) leaves it untouched.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (arb_point) begin
            beat_cnt_d = 8'd0;
        end else if (accepted && (beat_cnt_q != MAX_B)) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    // Beat counter register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            beat_cnt_q <= 8'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    // While the owner drives SEQ the burst is protected; otherwise the
    // owner gives up the bus when it stops requesting, goes idle, or has
    // used up its beat allowance while someone else waits.
    assign own_point = Hreadyout && (g_trans != TR_SEQ) &&
                       (!g_req || (g_trans == TR_IDLE) || beat_limit);

    // Parked: any request triggers arbitration as soon as the bridge is ready.
    assign arb_point = (state_q == ST_OWN) ? own_point : (Hreadyout && any_req);

    // Next owner / state at an arbitration point; otherwise hold.
    always_comb begin
        state_d   = state_q;
        hmaster_d = hmaster_q;
        if (arb_point) begin
            if (any_req) begin
                state_d   = ST_OWN;
                hmaster_d = winner;
            end else begin
                state_d   = ST_PARK;
                hmaster_d = DEF_IDX;
            end
        end
    end

    // The data phase belongs to whoever owned the address phase on the
    // last ready edge; a stalled data phase keeps its owner.
    always_comb begin
        hmaster_data_d = hmaster_data_q;
        if (Hreadyout) begin
            hmaster_data_d = hmaster_q;
        end
    end

    // One-hot grant decoded from the next owner so the output is registered
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_grant
            assign grant_d[gi] = (hmaster_d == 2'(gi));
        end
    endgenerate

    // Arbiter registers; reset parks the bus on the default master.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q        <= ST_PARK;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            grant_q        <= DEF_GRANT;
        end else begin
            state_q        <= state_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            grant_q        <= grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Bridge-side muxes
    // ------------------------------------------------------------------
    // Htrans is gated by reset so the bridge never sees a transfer while
    // the system is held in reset.
    assign Htrans       = Hresetn ? g_trans : TR_IDLE;
    assign Haddr        = addr4[hmaster_q];
    assign Hwrite       = write4[hmaster_q];
    assign Hwdata       = wdata4[hmaster_data_q];
    assign Hreadyin     = Hreadyout;
    assign m_hgrant     = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Self-checking bench for ahb_bridge_arbiter (NUM_M=2, MAX_BEATS=2).
// A behavioural model tracks owner / data owner / beat count as integers and
// predicts every bridge-side output each cycle; directed scenarios are
// followed by a randomized phase and an asynchronous reset mid-burst.
module tb_ahb_bridge_arbiter;

    localparam int NUM_M     = 2;
    localparam int MAX_BEATS = 2;
    localparam int DEFAULT_M = 0;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic                Hclk = 1'b0;
    logic                Hresetn = 1'b0;
    logic [NUM_M-1:0]    m_hreq;
    logic [2*NUM_M-1:0]  m_htrans;
    logic [32*NUM_M-1:0] m_haddr;
    logic [NUM_M-1:0]    m_hwrite;
    logic [32*NUM_M-1:0] m_hwdata;
    logic [NUM_M-1:0]    m_hgrant;
    logic                Hreadyout;
    logic [1:0]          Htrans;
    logic [31:0]         Haddr;
    logic                Hwrite;
    logic [31:0]         Hwdata;
    logic                Hreadyin;
    logic [1:0]          hmaster;
    logic [1:0]          hmaster_data;

    // Per-master stimulus
    logic        rq [NUM_M];
    logic [1:0]  tr [NUM_M];
    logic [31:0] ad [NUM_M];
    logic        wr [NUM_M];
    logic [31:0] wd [NUM_M];
    logic        hrdy;

    // Model state
    int mo;   // address-phase owner
    int md;   // data-phase owner
    int mb;   // beats since last arbitration
    bit mp;   // parked

    int checks   = 0;
    int failures = 0;

    ahb_bridge_arbiter #(
        .NUM_M     (NUM_M),
        .MAX_BEATS (MAX_BEATS),
        .DEFAULT_M (DEFAULT_M)
    ) dut (
        .Hclk         (Hclk),
        .Hresetn      (Hresetn),
        .m_hreq       (m_hreq),
        .m_htrans     (m_htrans),
        .m_haddr      (m_haddr),
        .m_hwrite     (m_hwrite),
        .m_hwdata     (m_hwdata),
        .m_hgrant     (m_hgrant),
        .Hreadyout    (Hreadyout),
        .Htrans       (Htrans),
        .Haddr        (Haddr),
        .Hwrite       (Hwrite),
        .Hwdata       (Hwdata),
        .Hreadyin     (Hreadyin),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data)
    );

    always #5 Hclk = ~Hclk;

    always_comb begin
        Hreadyout = hrdy;
        m_hreq    = '0;
        m_htrans  = '0;
        m_haddr   = '0;
        m_hwrite  = '0;
        m_hwdata  = '0;
        for (int j = 0; j < NUM_M; j++) begin
            m_hreq[j]          = rq[j];
            m_htrans[2*j +: 2] = tr[j];
            m_haddr[32*j +: 32] = ad[j];
            m_hwrite[j]        = wr[j];
            m_hwdata[32*j +: 32] = wd[j];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_m(input int i, input logic r, input logic [1:0] t,
                         input logic [31:0] a, input logic w, input logic [31:0] d);
        rq[i] = r; tr[i] = t; ad[i] = a; wr[i] = w; wd[i] = d;
    endtask

    task automatic model_reset();
        mo = DEFAULT_M; md = DEFAULT_M; mb = 0; mp = 1'b1;
    endtask

    // Next owner chosen among current requesters
    function automatic int pick();
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int j = 0; j < NUM_M; j++) if (rq[j]) return j;
`else
        for (int k = 1; k <= NUM_M; k++) if (rq[(mo + k) % NUM_M]) return (mo + k) % NUM_M;
`endif
        return DEFAULT_M;
    endfunction

    task automatic check_outputs();
        check("grant",        32'(m_hgrant),     32'(1) << mo);
        check("hmaster",      32'(hmaster),      32'(mo));
        check("hmaster_data", 32'(hmaster_data), 32'(md));
        check("Htrans",       32'(Htrans),       32'(tr[mo]));
        check("Haddr",        Haddr,             ad[mo]);
        check("Hwrite",       32'(Hwrite),       32'(wr[mo]));
        check("Hwdata",       Hwdata,            wd[md]);
        check("Hreadyin",     32'(Hreadyin),     32'(hrdy));
    endtask

    // One Hclk: check outputs mid-cycle, predict the edge, commit after it.
    task automatic run_cycle();
        int  t, nmo, nmd, nmb;
        bit  nmp, anyr, others, point;
        @(negedge Hclk);
        check_outputs();
        nmo = mo; nmd = md; nmb = mb; nmp = mp;
        if (hrdy) begin
            t = int'(tr[mo]);
            anyr = 1'b0; others = 1'b0;
            for (int j = 0; j < NUM_M; j++) begin
                if (rq[j]) anyr = 1'b1;
                if (rq[j] && j != mo) others = 1'b1;
            end
            nmd = mo;
            if (t >= 2) begin
                nmb = (mb < MAX_BEATS) ? mb + 1 : MAX_BEATS;
                $display("XFER t=%0t m%0d %s addr=%h", $time, mo, wr[mo] ? "WR" : "RD", ad[mo]);
            end
`ifdef AHB_ARB_FIXED_PRIO_EN
            point = mp ? anyr : (t != 3 && (!rq[mo] || t == 0));
`else
            point = mp ? anyr : (t != 3 && (!rq[mo] || t == 0 || (mb == MAX_BEATS && others)));
`endif
            if (point) begin
                nmb = 0;
                if (anyr) begin nmp = 1'b0; nmo = pick(); end
                else      begin nmp = 1'b1; nmo = DEFAULT_M; end
            end
        end
        @(posedge Hclk);
        #1;
        mo = nmo; md = nmd; mb = nmb; mp = nmp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        for (int j = 0; j < NUM_M; j++) set_m(j, 1'b0, IDLE, 32'h0, 1'b0, 32'h0);
        hrdy = 1'b1;
        model_reset();

        // Reset: master 0 tries to drive NONSEQ but Htrans must stay IDLE
        set_m(0, 1'b0, NONSEQ, 32'h8000_0000, 1'b1, 32'h0);
        repeat (2) @(posedge Hclk);
        #1;
        check("reset_htrans", 32'(Htrans), 32'h0);
        check("reset_grant",  32'(m_hgrant), 32'h1);
        Hresetn = 1'b1;
        set_m(0, 1'b0, IDLE, 32'h0, 1'b0, 32'h0);
        run_cycle();
        check("park_grant", 32'(m_hgrant), 32'h1);

        // Master 1 single NONSEQ write, granted one Hclk after request
        set_m(1, 1'b1, NONSEQ, 32'h8000_0011, 1'b1, 32'h8000_0011);
        run_cycle();
        check("grant_latency", 32'(m_hgrant), 32'h2);
        check("m1_addr", Haddr, 32'h8000_0011);
        run_cycle();
        set_m(1, 1'b1, IDLE, 32'h0, 1'b0, 32'h8000_0011);
        check("m1_wdata", Hwdata, 32'h8000_0011);
        run_cycle();

        // Both request; master 0 runs a 4-beat burst with a stall inside
        set_m(0, 1'b1, IDLE, 32'h0, 1'b1, 32'h0);
        run_cycle();
        check("burst_grant", 32'(m_hgrant), 32'h1);
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1'b1, (b == 0) ? NONSEQ : SEQ, 32'h8000_0050 + 32'(4 * b), 1'b1, $urandom);
            if (b == 2) begin
                hrdy = 1'b0;
                run_cycle();
                check("burst_stall_grant", 32'(m_hgrant), 32'h1);
                hrdy = 1'b1;
            end
            run_cycle();
            check("burst_no_handover", 32'(m_hgrant), 32'h1);
        end
        set_m(0, 1'b1, IDLE, 32'h0, 1'b1, $urandom);
        run_cycle();
        check("burst_handover", 32'(m_hgrant), 32'h2);

        // Beat limit: master 0 streams NONSEQ while master 1 keeps requesting
        set_m(0, 1'b1, NONSEQ, 32'h8000_0100, 1'b1, $urandom);
        run_cycle();
        check("beats_grant_m0", 32'(m_hgrant), 32'h1);
        for (int b = 0; b < 2; b++) begin
            set_m(0, 1'b1, NONSEQ, 32'h8000_0104 + 32'(4 * b), 1'b1, $urandom);
            run_cycle();
            check("beats_hold", 32'(m_hgrant), 32'h1);
        end
        run_cycle();
        check("beats_yield", 32'(m_hgrant), 32'h2);
        set_m(1, 1'b1, NONSEQ, 32'h8000_0200, 1'b1, $urandom);
        run_cycle();
        check("m1_keeps", 32'(m_hgrant), 32'h2);
        set_m(1, 1'b0, IDLE, 32'h0, 1'b0, $urandom);
        run_cycle();
        check("m0_regrant", 32'(m_hgrant), 32'h1);

        // Everyone drops: park on default, then a master 1 read
        set_m(0, 1'b0, IDLE, 32'h0, 1'b0, 32'h0);
        run_cycle();
        run_cycle();
        check("parked", 32'(m_hgrant), 32'h1);
        set_m(1, 1'b1, NONSEQ, 32'h8000_00AA, 1'b0, 32'h0);
        run_cycle();
        check("read_grant", 32'(m_hgrant), 32'h2);
        check("read_addr",  Haddr, 32'h8000_00AA);
        check("read_dir",   32'(Hwrite), 32'h0);
        run_cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < NUM_M; j++)
                set_m(j, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                      $urandom, 1'($urandom), $urandom);
            hrdy = $urandom_range(0, 3) != 0;
            run_cycle();
        end

        // Asynchronous reset in the middle of a master 1 burst
        hrdy = 1'b1;
        set_m(0, 1'b0, IDLE, 32'h0, 1'b0, 32'h0);
        set_m(1, 1'b1, IDLE, 32'h0, 1'b1, 32'h0);
        done = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            run_cycle();
            if (mo == 1) done = 1'b1;
        end
        check("handover_timeout", 32'(done), 32'h1);
        set_m(1, 1'b1, NONSEQ, 32'h8000_0300, 1'b1, 32'hA5A5_0000);
        run_cycle();
        set_m(1, 1'b1, SEQ, 32'h8000_0304, 1'b1, 32'hA5A5_0001);
        run_cycle();
        #2;
        Hresetn = 1'b0;
        #1;
        check("arst_grant",        32'(m_hgrant),     32'h1);
        check("arst_hmaster",      32'(hmaster),      32'h0);
        check("arst_hmaster_data", 32'(hmaster_data), 32'h0);
        check("arst_htrans",       32'(Htrans),       32'h0);
        model_reset();
        @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        set_m(1, 1'b0, IDLE, 32'h0, 1'b0, 32'h0);
        repeat (3) run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_bridge_arbiter.md
Name: ahb_bridge_arbiter

Overview:
- Shares the single AHB-lite slave port of the AHB-to-APB bridge (Bridge_Top) between NUM_M AHB-lite masters.
- Registered round-robin arbiter with burst protection, a beat-limit fairness counter and data-phase ownership tracking.
- Sits between the masters and Bridge_Top on the Hclk domain. Muxes the granted master's address/control and the data-phase owner's Hwdata onto the bridge.

Parameters:
- NUM_M, 2, number of masters; legal 2..4.
- MAX_BEATS, 8, accepted transfers after which the current owner yields at the next non-SEQ point if another master requests; legal 1..255.
- DEFAULT_M, 0, park master when no requests are pending.

Ports:
- Hclk  in  1  single clock, shared with the bridge AHB side.
- Hresetn  in  1  asynchronous active-low reset.
- m_hreq  in  NUM_M  per-master bus request.
- m_htrans  in  2*NUM_M  per-master Htrans, master i at [2i+1:2i].
- m_haddr  in  32*NUM_M  per-master Haddr.
- m_hwrite  in  NUM_M  per-master Hwrite.
- m_hwdata  in  32*NUM_M  per-master Hwdata.
- m_hgrant  out  NUM_M  one-hot registered grant.
- Hreadyout  in  1  from bridge; also broadcast unchanged to all masters by top level.
- Htrans  out  2  to bridge.
- Haddr  out  32  to bridge.
- Hwrite  out  1  to bridge.
- Hwdata  out  32  to bridge.
- Hreadyin  out  1  to bridge; equals Hreadyout.
- hmaster  out  2  index of the address-phase owner.
- hmaster_data  out  2  index of the data-phase owner.

Behaviour:
- Reset (async, Hresetn=0):
  - m_hgrant=one-hot(DEFAULT_M), hmaster=hmaster_data=DEFAULT_M.
  - beat_cnt=0, state=PARK.
  - Htrans forced 2'b00 while reset is asserted.
- Address mux (combinational from hmaster): Htrans/Haddr/Hwrite come from master hmaster. Non-granted masters never reach the bridge.
- Data mux: Hwdata=m_hwdata[hmaster_data].
- Data-phase ownership: hmaster_data<=hmaster on every Hclk edge with Hreadyout=1. It holds while Hreadyout=0.
- "Accepted" means Hreadyout=1 and the granted Htrans is NONSEQ (10) or SEQ (11).
- beat_cnt increments on each accepted transfer, saturates at MAX_BEATS, and clears on every grant change.
- States:
  - PARK: no master owns the bus; grant sits on DEFAULT_M. Any m_hreq=1 -> arbitrate -> OWN. Grant change registered on the next edge.
  - OWN: the granted master holds the bus. Arbitration point = Hreadyout=1 AND granted Htrans!=SEQ AND (granted m_hreq=0 OR granted Htrans=IDLE OR (beat_cnt==MAX_BEATS AND another m_hreq=1)). At the point: winner registered; goes to PARK if no requests.
  - SEQ transfers are never preempted. Hreadyout=0 freezes grant, beat_cnt and hmaster_data.
- Round-robin:
  - Search starts at hmaster+1 modulo NUM_M; the current owner is lowest priority.
  - A single requester is regranted to itself, which also clears beat_cnt.
- Latency: request to m_hgrant high is 1 Hclk when an arbitration point exists that cycle.
- Handover: a NONSEQ accepted at the arbitration cycle completes normally. Its data phase uses the old master's Hwdata via hmaster_data.
- Simultaneous events: a grant change and hmaster_data update on the same edge are both legal. hmaster_data takes the pre-edge hmaster.
- Reset mid-transfer: all state returns to reset values immediately. Any in-flight bridge transfer is abandoned. The bridge resets on the same Hresetn.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, master 0 highest. Arbitration points and SEQ protection are unchanged. Beat-limit yielding is disabled, and beat_cnt is not implemented.
- Undefined: round-robin with MAX_BEATS fairness as above.

Test Plan:
- Reset, no requests -> m_hgrant=2'b01, Htrans=00, hmaster=0.
- m_hreq=2'b10, master1 NONSEQ write to 32'h8000_0011 with data 32'h8000_0011 -> grant 2'b10 after 1 Hclk; bridge shows Paddr=32'h8000_0011, Pwdata=32'h8000_0011.
- Both request; master0 runs a 4-beat burst NONSEQ+SEQ to 8000_0050..5C -> no handover during SEQ beats; grant moves to master1 after the final beat; hmaster_data tracks the owner across Hreadyout stalls.
- MAX_BEATS=2, master0 issues continuous NONSEQ writes, master1 requesting -> grant swaps after 2 accepted beats; master0 is regranted only after master1 yields.
- Both masters drop requests -> return to PARK with grant=one-hot(DEFAULT_M); a master1 read of 32'h8000_00AA then returns Prdata 32'h1234_5678 on Hrdata.
- Hresetn pulsed low mid-burst -> grant, hmaster and hmaster_data return to 0 asynchronously and Htrans=00.
